// File: rtl/risc16_boot_loader.sv
// Boot loader for risc16b: receives a framed byte stream, writes 16-bit words to instruction
// memory and holds the core in reset until the checksum verifies. Optional: LOADER_TIMEOUT_EN.
module risc16_boot_loader #(
    parameter logic [15:0] BASE_ADDR      = 16'h0000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned MAX_WORDS      = 32768,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] m_addr,
    output logic [15:0] m_dout,
    output logic [1:0]  m_we,
    output logic        core_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle, StLenH, StLenL, StDataH, StDataL, StCsum, StRun, StError
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  len_h_q, len_h_d;
    logic [7:0]  data_h_q, data_h_d;
    logic [7:0]  sum_q, sum_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] m_addr_q, m_addr_d;
    logic [15:0] m_dout_q, m_dout_d;
    logic [1:0]  m_we_q, m_we_d;
    logic        accept;
    logic        active;
    logic [15:0] len_word;

    assign rx_ready = (state_q != StRun);
    assign accept   = rx_valid && rx_ready;
    assign active   = (state_q == StLenH) || (state_q == StLenL) || (state_q == StDataH) ||
                      (state_q == StDataL) || (state_q == StCsum);
    assign len_word = {len_h_q, rx_data};

    assign core_rst = (state_q != StRun);
    assign done     = (state_q == StRun);
    assign err      = (state_q == StError);
    assign m_addr   = m_addr_q;
    assign m_dout   = m_dout_q;
    assign m_we     = m_we_q;

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        tmo_hit;

    always_comb begin
        tmo_d = 32'd0;
        if (!accept && active) begin
            tmo_d = tmo_q + 32'd1;
        end
    end
    assign tmo_hit = !accept && active && (tmo_q == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= 32'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic tmo_hit;
    logic unused_timeout;
    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        len_h_d  = len_h_q;
        data_h_d = data_h_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        m_addr_d = m_addr_q;
        m_dout_d = m_dout_q;
        m_we_d   = 2'b00;

        if (accept) begin
            unique case (state_q)
                StIdle, StError: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = StLenH;
                        sum_d   = 8'd0;
                        idx_d   = 16'd0;
                    end
                end
                StLenH: begin
                    len_h_d = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = StLenL;
                end
                StLenL: begin
                    sum_d = sum_q + rx_data;
                    cnt_d = len_word;
                    if (32'(len_word) > MAX_WORDS) begin
                        state_d = StError;
                    end else if (len_word == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StDataH;
                    end
                end
                StDataH: begin
                    data_h_d = rx_data;
                    sum_d    = sum_q + rx_data;
                    state_d  = StDataL;
                end
                StDataL: begin
                    sum_d    = sum_q + rx_data;
                    m_we_d   = 2'b11;
                    m_dout_d = {data_h_q, rx_data};
                    // Word index scaled to a byte offset; wraps modulo 2^16.
                    m_addr_d = BASE_ADDR + {idx_q[14:0], 1'b0};
                    idx_d    = idx_q + 16'd1;
                    cnt_d    = cnt_q - 16'd1;
                    state_d  = (cnt_q == 16'd1) ? StCsum : StDataH;
                end
                StCsum: begin
                    state_d = (rx_data == sum_q) ? StRun : StError;
                end
                default: ;
            endcase
        end else if (tmo_hit) begin
            state_d = StError;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            len_h_q  <= 8'd0;
            data_h_q <= 8'd0;
            sum_q    <= 8'd0;
            cnt_q    <= 16'd0;
            idx_q    <= 16'd0;
            m_addr_q <= 16'd0;
            m_dout_q <= 16'd0;
            m_we_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            len_h_q  <= len_h_d;
            data_h_q <= data_h_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            m_addr_q <= m_addr_d;
            m_dout_q <= m_dout_d;
            m_we_q   <= m_we_d;
        end
    end

endmodule

// File: doc/risc16_boot_loader.md
Name: risc16_boot_loader

Overview:
Upstream neighbour of the risc16b core. It receives a program image as a byte stream over a valid/ready handshake and writes it as 16-bit words into instruction memory. The instruction memory write port uses the same addressing and byte-enable style as the core's data port. The block holds the core in reset until the image is loaded and its checksum verifies, then releases it.

Parameters:
BASE_ADDR, 16'h0000, byte address of the first loaded word.
SYNC_BYTE, 8'hA5, frame start marker.
MAX_WORDS, 32768, largest accepted word count; a larger count is a frame error.
TIMEOUT_CYCLES, 50000, inter-byte timeout in cycles; used only with LOADER_TIMEOUT_EN.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
rx_data  in  8  stream byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready
m_addr  out  16  instruction memory byte address, always even
m_dout  out  16  instruction memory write data
m_we  out  2  byte write enables: 2'b11 = full word, 2'b00 = no write
core_rst  out  1  active-high reset to the core
done  out  1  image loaded and verified
err  out  1  frame error

Behaviour:
- One clock, synchronous reset. Reset is sampled on the rising edge of clk while rst=0.
- Reset values: state=IDLE, m_addr=0, m_dout=0, m_we=2'b00, core_rst=1, done=0, err=0. rx_ready is decoded from state, so it is 1 after reset.
- rx_ready: 1 in every state except RUN. Back-to-back transfers are allowed, one byte per cycle.
- Frame format: SYNC, LEN_H, LEN_L, N×(DATA_H, DATA_L), CSUM.
  - N = {LEN_H, LEN_L}.
  - Each word is big-endian: {DATA_H, DATA_L}.
  - CSUM = 8-bit sum mod 256 of LEN_H, LEN_L and all data bytes.
- States and transitions (all on accepted bytes unless noted):
  - IDLE: SYNC_BYTE goes to LEN_H; any other byte is discarded.
  - LEN_H: store byte, go to LEN_L.
  - LEN_L: if N > MAX_WORDS go to ERROR; if N == 0 go to CSUM; otherwise go to DATA_H.
  - DATA_H: latch high byte, go to DATA_L.
  - DATA_L: word write, see below. Decrement the remaining count; go to CSUM when it reaches 0, otherwise to DATA_H.
  - CSUM: byte == running sum goes to RUN; otherwise goes to ERROR.
  - RUN: core_rst=0, done=1, rx_ready=0. RUN is left only by reset.
  - ERROR: err=1, core_rst=1, done=0. Accepted bytes are discarded, except SYNC_BYTE, which clears err and goes to LEN_H.
- The running sum and the word index clear whenever SYNC_BYTE is accepted in IDLE or ERROR.
- Word write timing: the DATA_L byte is accepted at edge k. During the cycle after edge k:
  - m_we = 2'b11,
  - m_dout = {DATA_H, DATA_L},
  - m_addr = BASE_ADDR + 2×index, 16-bit, wraps modulo 2^16.
  - m_we = 2'b00 in every other cycle. m_addr and m_dout hold their last values.
- Release timing: core_rst falls and done rises at the edge following the accepted correct CSUM. Because CSUM arrives at least one cycle after the last DATA_L, the final write always completes before core_rst falls.
- Reset mid-frame or in RUN: state returns to IDLE, any write in progress is dropped, core_rst=1. The next frame loads starting again at BASE_ADDR.
- rx_valid low: state is held. No timeout unless the optional feature is enabled.

Optional Feature:
Macro LOADER_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and increments each cycle while in LEN_H, LEN_L, DATA_H, DATA_L or CSUM. When it reaches TIMEOUT_CYCLES the state goes to ERROR: err=1, no further writes.
- Undefined: no counter; the loader waits indefinitely, and TIMEOUT_CYCLES is unused.

Test Plan:
1. Good load. Stream A5 00 02 12 34 56 78 16.
   - Writes: (0x0000, 0x1234, m_we=11), then (0x0002, 0x5678).
   - Then done=1, core_rst=0, rx_ready=0.
2. Bad checksum, then recovery.
   - Stream A5 00 01 AA BB 00 → one write (0x0000, 0xAABB), then err=1, core_rst=1.
   - Then stream A5 00 00 00 → err=0, done=1, core_rst=0, no writes.
3. Junk before sync. Stream 00 FF 5A, then case 1 → no writes for the junk bytes; results identical to case 1.
4. Oversize length, with MAX_WORDS=4. Stream A5 00 05 → err=1 after LEN_L, m_we stays 00.
5. Throttled stream plus reset.
   - Case 1 with 3 idle cycles between every byte → the same writes and result.
   - Repeat, but drive rst=0 for 1 cycle after byte 5 → IDLE, core_rst=1, no write for the partial word; a full resend of case 1 then loads correctly.
6. Timeout, with LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10.
   - Send A5 00 then idle → err=1 exactly 10 cycles after the last accept.
   - Without the macro → still waiting after 1000 cycles, err=0.
